// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, requester IDs and write-back payload type for the
// register-file write-back scheduler.
package regfile_wb_scheduler_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 8;

    localparam int unsigned WB_ALU = 0;
    localparam int unsigned WB_MEM = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, write-back request and register-file write port bundle of the
// write-back scheduler.
interface regfile_wb_scheduler_if;
    import regfile_wb_scheduler_pkg::*;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rs1;
    logic [ADDR_W-1:0] issue_rs2;
    logic              issue_use_rs1;
    logic              issue_use_rs2;
    logic              issue_has_rd;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_stall;

    logic              alu_wb_valid;
    logic [ADDR_W-1:0] alu_wb_rd;
    logic [DATA_W-1:0] alu_wb_data;
    logic              alu_wb_ready;

    logic              mem_wb_valid;
    logic [ADDR_W-1:0] mem_wb_rd;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_wb_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [NREG-1:0]   busy;
    logic              wb_err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_has_rd, issue_rd,
               alu_wb_valid, alu_wb_rd, alu_wb_data,
               mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  issue_stall, alu_wb_ready, mem_wb_ready,
               rf_we, rf_wa, rf_wd, busy, wb_err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_has_rd, issue_rd,
               alu_wb_valid, alu_wb_rd, alu_wb_data,
               mem_wb_valid, mem_wb_rd, mem_wb_data,
        output issue_stall, alu_wb_ready, mem_wb_ready,
               rf_we, rf_wa, rf_wd, busy, wb_err
    );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; a lone requester always wins, contention
// goes to the requester that did not win last.
module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt         = 2'b00;
        gnt[WB_ALU] = req[WB_ALU] & (~req[WB_MEM] | (last_q == 1'(WB_MEM)));
        gnt[WB_MEM] = req[WB_MEM] & (~req[WB_ALU] | (last_q == 1'(WB_ALU)));
    end

    // Reset favours ALU in the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'(WB_MEM);
        end else if (|gnt) begin
            last_q <= gnt[WB_MEM];
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates the single register-file write port and
// keeps the outstanding-write scoreboard that stalls RAW/WAW issue.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_scheduler_if.slave bus
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              xfer_c;
    logic              accept_c;
    logic              err_c;
    wb_req_t           win_c;
    logic [NREG-1:0]   busy_nxt;

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_wa_q;
    logic [DATA_W-1:0] rf_wd_q;
    logic [NREG-1:0]   busy_q;
    logic              wb_err_q;

    assign req = {bus.mem_wb_valid, bus.alu_wb_valid};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.alu_wb_ready = gnt[WB_ALU];
    assign bus.mem_wb_ready = gnt[WB_MEM];
    assign xfer_c           = |gnt;

    assign bus.issue_stall = bus.issue_valid &
                             ((bus.issue_use_rs1 & busy_q[bus.issue_rs1]) |
                              (bus.issue_use_rs2 & busy_q[bus.issue_rs2]) |
                              (bus.issue_has_rd  & busy_q[bus.issue_rd]));
    assign accept_c = bus.issue_valid & ~bus.issue_stall;

    // Winner payload, scoreboard next state and error detection.
    always_comb begin
        win_c    = '{rd: bus.alu_wb_rd, data: bus.alu_wb_data};
        busy_nxt = busy_q;
        err_c    = 1'b0;
        if (gnt[WB_MEM]) begin
            win_c = '{rd: bus.mem_wb_rd, data: bus.mem_wb_data};
        end
        // Clear before set so a same-edge reallocation leaves the bit set.
        if (rf_we_q) begin
            busy_nxt[rf_wa_q] = 1'b0;
        end
        if (accept_c && bus.issue_has_rd) begin
            busy_nxt[bus.issue_rd] = 1'b1;
        end
        if (xfer_c && !busy_q[win_c.rd] && !(rf_we_q && (rf_wa_q == win_c.rd))) begin
            err_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            rf_we_q <= xfer_c;
            if (xfer_c) begin
                rf_wa_q <= win_c.rd;
                rf_wd_q <= win_c.data;
            end
            busy_q <= busy_nxt;
            if (err_c) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    assign bus.rf_we  = rf_we_q;
    assign bus.rf_wa  = rf_wa_q;
    assign bus.rf_wd  = rf_wd_q;
    assign bus.busy   = busy_q;
    assign bus.wb_err = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed issue/write-back
// vectors, with register-file writes checked by a separate monitor.
module tb_regfile_wb_scheduler;
    import regfile_wb_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    wb_req_t exp_q[$];

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register-file write must match the next expected write.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            wb_req_t got;
            wb_req_t want;
            got = '{rd: bus.rf_wa, data: bus.rf_wd};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write_unexpected: got wa=%0d wd=%h expected none", got.rd, got.data);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL rf_write: got wa=%0d wd=%h expected wa=%0d wd=%h",
                             got.rd, got.data, want.rd, want.data);
                end
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_rs1     = '0;
        bus.issue_rs2     = '0;
        bus.issue_use_rs1 = 1'b0;
        bus.issue_use_rs2 = 1'b0;
        bus.issue_has_rd  = 1'b0;
        bus.issue_rd      = '0;
        bus.alu_wb_valid  = 1'b0;
        bus.alu_wb_rd     = '0;
        bus.alu_wb_data   = '0;
        bus.mem_wb_valid  = 1'b0;
        bus.mem_wb_rd     = '0;
        bus.mem_wb_data   = '0;

        tick();
        chk("reset_rf_we",  32'(bus.rf_we),  32'h0);
        chk("reset_rf_wa",  32'(bus.rf_wa),  32'h0);
        chk("reset_rf_wd",  32'(bus.rf_wd),  32'h0);
        chk("reset_busy",   32'(bus.busy),   32'h0);
        chk("reset_wb_err", 32'(bus.wb_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write-back to r5.
        tick();
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 3'd5;
        #1 chk("issue_r5_stall", 32'(bus.issue_stall), 32'h0);
        tick();
        bus.issue_valid  = 1'b0;
        bus.issue_has_rd = 1'b0;
        chk("busy5_set", 32'(bus.busy), 32'h20);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 3'd5;
        bus.alu_wb_data  = 16'hBEEF;
        exp_q.push_back('{rd: 3'd5, data: 16'hBEEF});
        #1 chk("alu_ready_r5", 32'(bus.alu_wb_ready), 32'h1);
        tick();
        bus.alu_wb_valid = 1'b0;
        chk("rf_we_r5",       32'(bus.rf_we), 32'h1);
        chk("busy5_held",     32'(bus.busy),  32'h20);
        tick();
        chk("busy5_cleared",  32'(bus.busy),   32'h0);
        chk("no_err_r5",      32'(bus.wb_err), 32'h0);

        // RAW/WAW hazards against r3.
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 3'd3;
        tick();
        chk("busy3_set", 32'(bus.busy), 32'h08);
        bus.issue_has_rd  = 1'b0;
        bus.issue_rs1     = 3'd3;
        bus.issue_use_rs1 = 1'b1;
        #1 chk("raw_stall", 32'(bus.issue_stall), 32'h1);
        bus.issue_use_rs1 = 1'b0;
        #1 chk("unused_rs1_no_stall", 32'(bus.issue_stall), 32'h0);
        bus.issue_has_rd  = 1'b1;
        bus.issue_rd      = 3'd3;
        #1 chk("waw_stall", 32'(bus.issue_stall), 32'h1);
        bus.issue_rd      = 3'd2;
        #1 chk("rd2_no_stall", 32'(bus.issue_stall), 32'h0);
        tick();
        bus.issue_valid  = 1'b0;
        bus.issue_has_rd = 1'b0;
        chk("busy_0c", 32'(bus.busy), 32'h0C);

        // Write-back to a non-busy register raises the sticky error.
        bus.mem_wb_valid = 1'b1;
        bus.mem_wb_rd    = 3'd6;
        bus.mem_wb_data  = 16'h6666;
        exp_q.push_back('{rd: 3'd6, data: 16'h6666});
        #1 chk("mem_ready_r6", 32'(bus.mem_wb_ready), 32'h1);
        tick();
        bus.mem_wb_valid = 1'b0;
        chk("wb_err_set", 32'(bus.wb_err), 32'h1);
        tick();
        chk("wb_err_sticky", 32'(bus.wb_err), 32'h1);

        // Reset while a write to r3 is in flight.
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 3'd3;
        bus.alu_wb_data  = 16'h3333;
        tick();
        bus.alu_wb_valid = 1'b0;
        chk("inflight_rf_we", 32'(bus.rf_we), 32'h1);
        chk("inflight_busy",  32'(bus.busy),  32'h0C);
        rst_n = 1'b0;
        #1;
        chk("async_rf_we",  32'(bus.rf_we),  32'h0);
        chk("async_busy",   32'(bus.busy),   32'h0);
        chk("async_wb_err", 32'(bus.wb_err), 32'h0);
        chk("async_rf_wa",  32'(bus.rf_wa),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention straight out of reset: ALU first, then MEM.
        tick();
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 3'd1;
        bus.alu_wb_data  = 16'h1111;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wb_rd    = 3'd2;
        bus.mem_wb_data  = 16'h2222;
        exp_q.push_back('{rd: 3'd1, data: 16'h1111});
        #1;
        chk("cont_alu_ready0", 32'(bus.alu_wb_ready), 32'h1);
        chk("cont_mem_ready0", 32'(bus.mem_wb_ready), 32'h0);
        tick();
        bus.alu_wb_valid = 1'b0;
        exp_q.push_back('{rd: 3'd2, data: 16'h2222});
        #1 chk("cont_mem_ready1", 32'(bus.mem_wb_ready), 32'h1);
        tick();
        bus.mem_wb_valid = 1'b0;

        // Fairness: both always valid, grants must alternate ALU, MEM, ...
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 3'd4;
        bus.alu_wb_data  = 16'hA000;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wb_rd    = 3'd7;
        bus.mem_wb_data  = 16'hB000;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i % 2 == 0) begin
                exp_q.push_back('{rd: 3'd4, data: 16'hA000 + 16'(i / 2)});
            end else begin
                exp_q.push_back('{rd: 3'd7, data: 16'hB000 + 16'(i / 2)});
            end
            chk($sformatf("fair_alu_ready%0d", i), 32'(bus.alu_wb_ready), 32'((i + 1) % 2));
            chk($sformatf("fair_mem_ready%0d", i), 32'(bus.mem_wb_ready), 32'(i % 2));
            tick();
            if (i % 2 == 0) begin
                bus.alu_wb_data = 16'hA000 + 16'(i / 2 + 1);
            end else begin
                bus.mem_wb_data = 16'hB000 + 16'(i / 2 + 1);
            end
        end
        bus.alu_wb_valid = 1'b0;
        bus.mem_wb_valid = 1'b0;

        repeat (3) tick();
        chk("writes_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
